// File: rtl/staged_counter_cmp.sv
// Cascaded STAGES x STAGE_W up/down counter with parallel load, per-stage carries,
// terminal-count pulse and a masked compare producing a match pulse and sticky flag.
module staged_counter_cmp #(
  parameter int unsigned STAGE_W = 4,
  parameter int unsigned STAGES  = 4,
  localparam int unsigned CNT_W  = STAGE_W * STAGES,
  parameter logic [CNT_W-1:0] RST_CMP = '1
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              EN,
  input  logic              DIR,
  input  logic              LOAD,
  input  logic [CNT_W-1:0]  LD_VAL,
  input  logic              CMP_WE,
  input  logic [CNT_W-1:0]  CMP_VAL,
  input  logic [CNT_W-1:0]  CMP_MASK,
  input  logic              CLR_STK,
  output logic [CNT_W-1:0]  Q,
  output logic [STAGES-1:0] CARRY,
  output logic              TC,
  output logic              Z,
  output logic              STK
);

  logic [CNT_W-1:0]  q_q, q_d;
  logic [CNT_W-1:0]  cmp_q, cmp_d;
  logic [CNT_W-1:0]  mask_q, mask_d;
  logic              tc_q, tc_d;
  logic              z_q, z_d;
  logic              stk_q, stk_d;

  logic [STAGES-1:0] cin;
  logic [STAGES-1:0] stage_term;
  logic [STAGES-1:0] carry_c;

  // Ripple cascade: a stage advances only when every lower stage is at its terminal value.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [STAGE_W-1:0] cur;
    assign cur = q_q[k*STAGE_W +: STAGE_W];

    assign stage_term[k] = DIR ? (cur == '0) : (cur == '1);

    if (k == 0) begin : g_first
      assign cin[k] = EN & ~LOAD;
    end else begin : g_next
      assign cin[k] = carry_c[k-1];
    end

    assign carry_c[k] = cin[k] & stage_term[k];

    assign q_d[k*STAGE_W +: STAGE_W] =
        LOAD   ? LD_VAL[k*STAGE_W +: STAGE_W] :
        cin[k] ? (DIR ? cur - STAGE_W'(1) : cur + STAGE_W'(1)) :
                 cur;
  end

  // Next-state for compare, terminal count, match and sticky flag.
  always_comb begin
    cmp_d  = cmp_q;
    mask_d = mask_q;
    if (CMP_WE) begin
      cmp_d  = CMP_VAL;
      mask_d = CMP_MASK;
    end
    tc_d  = carry_c[STAGES-1];
    z_d   = (EN | LOAD) & (((q_d ^ cmp_q) & mask_q) == '0);
    stk_d = z_d | (stk_q & ~CLR_STK);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      q_q    <= '0;
      cmp_q  <= RST_CMP;
      mask_q <= '1;
      tc_q   <= 1'b0;
      z_q    <= 1'b0;
      stk_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      cmp_q  <= cmp_d;
      mask_q <= mask_d;
      tc_q   <= tc_d;
      z_q    <= z_d;
      stk_q  <= stk_d;
    end
  end

  // Carries are forced low while reset is held, even if DIR=1 would flag Q=0 as terminal.
  assign CARRY = RST ? '0 : carry_c;
  assign Q     = q_q;
  assign TC    = tc_q;
  assign Z     = z_q;
  assign STK   = stk_q;

endmodule

// File: tb/tb_staged_counter_cmp.sv
// Directed, table-driven bench for staged_counter_cmp with default 4x4 geometry.
module tb_staged_counter_cmp;

  logic        CK;
  logic        RST;
  logic        EN;
  logic        DIR;
  logic        LOAD;
  logic [15:0] LD_VAL;
  logic        CMP_WE;
  logic [15:0] CMP_VAL;
  logic [15:0] CMP_MASK;
  logic        CLR_STK;
  logic [15:0] Q;
  logic [3:0]  CARRY;
  logic        TC;
  logic        Z;
  logic        STK;

  int checks;
  int failures;

  staged_counter_cmp dut (
    .CK(CK), .RST(RST), .EN(EN), .DIR(DIR), .LOAD(LOAD), .LD_VAL(LD_VAL),
    .CMP_WE(CMP_WE), .CMP_VAL(CMP_VAL), .CMP_MASK(CMP_MASK), .CLR_STK(CLR_STK),
    .Q(Q), .CARRY(CARRY), .TC(TC), .Z(Z), .STK(STK)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  typedef struct {
    logic        en;
    logic        dir;
    logic        load;
    logic [15:0] ld;
    logic        we;
    logic [15:0] cv;
    logic [15:0] cm;
    logic        clr;
    logic [3:0]  carry;  // expected before the edge
    logic [15:0] q;      // expected after the edge
    logic        tc;
    logic        z;
    logic        stk;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic en, input logic dir, input logic load,
                              input logic [15:0] ld, input logic we,
                              input logic [15:0] cv, input logic [15:0] cm,
                              input logic clr, input logic [3:0] carry,
                              input logic [15:0] q, input logic tc,
                              input logic z, input logic stk);
    vec_t v;
    v.en = en; v.dir = dir; v.load = load; v.ld = ld; v.we = we;
    v.cv = cv; v.cm = cm; v.clr = clr; v.carry = carry;
    v.q = q; v.tc = tc; v.z = z; v.stk = stk;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    EN = v.en; DIR = v.dir; LOAD = v.load; LD_VAL = v.ld; CMP_WE = v.we;
    CMP_VAL = v.cv; CMP_MASK = v.cm; CLR_STK = v.clr;
  endtask

  task automatic step(input logic en, input logic dir, input logic load,
                      input logic [15:0] ld);
    @(negedge CK);
    EN = en; DIR = dir; LOAD = load; LD_VAL = ld;
    CMP_WE = 1'b0; CLR_STK = 1'b0;
    @(posedge CK);
    #1;
  endtask

  initial begin
    logic s;
    checks = 0;
    failures = 0;

    // A: 16 up-counts from 0; only stage 0 carries, at Q=0x000F
    for (int i = 1; i <= 16; i++)
      add(1, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, (i == 16) ? 4'b0001 : 4'b0000,
          16'(i), 0, 0, 0);
    // B..G: wrap up through max, then down through zero (reset compare = 0xFFFF)
    add(0, 0, 1, 16'hFFFE, 0, 16'h0, 16'h0, 0, 4'b0000, 16'hFFFE, 0, 0, 0);
    add(1, 0, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b0000, 16'hFFFF, 0, 1, 1);
    add(1, 0, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b1111, 16'h0000, 1, 0, 1);
    add(1, 0, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b0000, 16'h0001, 0, 0, 1);
    add(1, 1, 0, 16'h0,    0, 16'h0, 16'h0, 1, 4'b0000, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b1111, 16'hFFFF, 1, 1, 1);
    // H..K: exact compare 0x0123; write lands with a load, old compare still used
    add(0, 0, 1, 16'h0120, 1, 16'h0123, 16'hFFFF, 1, 4'b0000, 16'h0120, 0, 0, 0);
    add(1, 0, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b0000, 16'h0121, 0, 0, 0);
    add(1, 0, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b0000, 16'h0122, 0, 0, 0);
    add(1, 0, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b0000, 16'h0123, 0, 1, 1);
    add(0, 0, 0, 16'h0,    0, 16'h0, 16'h0, 0, 4'b0000, 16'h0123, 0, 0, 1);
    add(0, 0, 0, 16'h0,    0, 16'h0, 16'h0, 1, 4'b0000, 16'h0123, 0, 0, 0);
    // L..M: masked compare on low nibble = 5, sticky clear races a match at 0x15
    add(0, 0, 1, 16'h0000, 1, 16'h0005, 16'h000F, 0, 4'b0000, 16'h0000, 0, 0, 0);
    s = 1'b0;
    for (int i = 1; i <= 16'h25; i++) begin
      logic z;
      logic clr;
      z   = ((i & 15) == 5);
      clr = (i == 16'h15) || (i == 16'h16);
      s   = z | (s & ~clr);
      add(1, 0, 0, 16'h0, 0, 16'h0, 16'h0, clr,
          (((i - 1) & 15) == 15) ? 4'b0001 : 4'b0000, 16'(i), 0, z, s);
    end
    // N..P: loads to max / matching value never raise TC and mask the carries
    add(0, 0, 0, 16'h0,    1, 16'h0123, 16'hFFFF, 0, 4'b0000, 16'h0025, 0, 0, 1);
    add(1, 0, 1, 16'hFFFF, 0, 16'h0, 16'h0, 0, 4'b0000, 16'hFFFF, 0, 0, 1);
    add(1, 0, 1, 16'h0123, 0, 16'h0, 16'h0, 0, 4'b0000, 16'h0123, 0, 1, 1);

    // Reset with EN=1 DIR=1 so an ungated carry would show at Q=0
    RST = 1'b1; EN = 1'b1; DIR = 1'b1; LOAD = 1'b0; LD_VAL = '0;
    CMP_WE = 1'b0; CMP_VAL = '0; CMP_MASK = '0; CLR_STK = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    check("reset_q", Q, 16'h0);
    check("reset_tc", 16'(TC), 16'h0);
    check("reset_z", 16'(Z), 16'h0);
    check("reset_stk", 16'(STK), 16'h0);
    check("reset_carry", 16'(CARRY), 16'h0);
    @(negedge CK);
    RST = 1'b0; EN = 1'b0; DIR = 1'b0;

    foreach (vq[i]) begin
      @(negedge CK);
      drive(vq[i]);
      #1;
      check($sformatf("v%0d_carry", i), 16'(CARRY), 16'(vq[i].carry));
      @(posedge CK);
      #1;
      check($sformatf("v%0d_q", i), Q, vq[i].q);
      check($sformatf("v%0d_tc", i), 16'(TC), 16'(vq[i].tc));
      check($sformatf("v%0d_z", i), 16'(Z), 16'(vq[i].z));
      check($sformatf("v%0d_stk", i), 16'(STK), 16'(vq[i].stk));
    end

    // Async reset mid-count at 0x00A7 with STK set; no match at 0xA0..0xA7
    step(0, 0, 1, 16'h00A0);
    check("a0_q", Q, 16'h00A0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 16'h0);
    check("a7_q", Q, 16'h00A7);
    check("a7_stk", 16'(STK), 16'h1);
    #2;
    DIR = 1'b1;
    RST = 1'b1;
    #1;
    check("async_q", Q, 16'h0);
    check("async_z", 16'(Z), 16'h0);
    check("async_tc", 16'(TC), 16'h0);
    check("async_stk", 16'(STK), 16'h0);
    check("async_carry", 16'(CARRY), 16'h0);
    @(negedge CK);
    RST = 1'b0; DIR = 1'b0;
    @(posedge CK);
    #1;
    check("post_reset_q", Q, 16'h0001);
    check("post_reset_tc", 16'(TC), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
